// File: rtl/ct_merge.sv
// ct_merge: round-robin merge of NI flow-tagged streams into one registered stream; CT_MERGE_PKT_LOCK_EN holds the grant for a whole packet.
module ct_merge #(
  parameter int NI = 2,
  parameter int WO = 8,
  parameter int WF = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NI*WO-1:0] i_data,
  input  logic [NI-1:0]    i_valid,
  input  logic [NI*WF-1:0] i_flow,
  input  logic [NI-1:0]    i_eop,
  output logic [NI-1:0]    o_ready,
  output logic [WO-1:0]    o_data,
  output logic             o_valid,
  output logic [WF-1:0]    o_flow,
  output logic             o_eop,
  input  logic             i_ready
);
  localparam int PW = NI > 1 ? $clog2(NI) : 1;
  logic [PW-1:0] ptr_q, ptr_d, g, idx, nxt;
  logic          gv, load, xfer;
  logic          o_valid_q, o_valid_d, o_eop_q, o_eop_d;
  logic [WO-1:0] o_data_q, o_data_d;
  logic [WF-1:0] o_flow_q, o_flow_d;
`ifdef CT_MERGE_PKT_LOCK_EN
  logic          lock_q, lock_d;
  logic [PW-1:0] lk_q, lk_d;
`endif
  always_comb begin
    g = '0;
    gv = 1'b0;
    idx = '0;
    // scan from the far end so the input nearest ptr is the last to win
    for (int k = NI - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr_q) + k) % NI);
      if (i_valid[idx]) begin
        g = idx;
        gv = 1'b1;
      end
    end
`ifdef CT_MERGE_PKT_LOCK_EN
    if (lock_q) begin
      g = lk_q;
      gv = 1'b1;
    end
`endif
    load = !o_valid_q | i_ready;
    o_ready = (gv & load & !reset) ? NI'(1) << g : '0;
    xfer = |(o_ready & i_valid);
    nxt = PW'((int'(g) + 1) % NI);
    o_valid_d = load ? xfer : o_valid_q;
    o_data_d = xfer ? i_data[WO*g +: WO] : o_data_q;
    o_flow_d = xfer ? i_flow[WF*g +: WF] : o_flow_q;
    o_eop_d = xfer ? i_eop[g] : o_eop_q;
`ifdef CT_MERGE_PKT_LOCK_EN
    lock_d = xfer ? !i_eop[g] : lock_q;
    lk_d = (xfer & !i_eop[g]) ? g : lk_q;
    ptr_d = (xfer & i_eop[g]) ? nxt : ptr_q;
`else
    ptr_d = xfer ? nxt : ptr_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      o_valid_q <= 1'b0;
      o_data_q <= '0;
      o_flow_q <= '0;
      o_eop_q <= 1'b0;
      ptr_q <= '0;
`ifdef CT_MERGE_PKT_LOCK_EN
      lock_q <= 1'b0;
      lk_q <= '0;
`endif
    end else begin
      o_valid_q <= o_valid_d;
      o_data_q <= o_data_d;
      o_flow_q <= o_flow_d;
      o_eop_q <= o_eop_d;
      ptr_q <= ptr_d;
`ifdef CT_MERGE_PKT_LOCK_EN
      lock_q <= lock_d;
      lk_q <= lk_d;
`endif
    end
  end
  assign o_valid = o_valid_q;
  assign o_data = o_data_q;
  assign o_flow = o_flow_q;
  assign o_eop = o_eop_q;
endmodule

// File: tb/tb_ct_merge.sv
// tb_ct_merge: randomized bench for ct_merge (NI=3) against a packet-level arbitration model; follows CT_MERGE_PKT_LOCK_EN.
module tb_ct_merge;
  localparam int NI = 3, WO = 8, WF = 1;
  logic clk = 0, rst = 1, rdy = 1;
  logic [NI*WO-1:0] i_data;
  logic [NI*WF-1:0] i_flow;
  logic [NI-1:0] i_valid, i_eop, o_ready;
  logic [WO-1:0] o_data;
  logic [WF-1:0] o_flow;
  logic o_valid, o_eop;
  logic [WO-1:0] d [NI];
  logic [WF-1:0] f [NI];
  logic v [NI], e [NI], acc [NI];
  int checks = 0, errors = 0;
  bit m_valid = 0, m_eop = 0, m_lock = 0;
  logic [WO-1:0] m_data = 0;
  logic [WF-1:0] m_flow = 0;
  int m_ptr = 0, m_lk = 0;

  ct_merge #(.NI(NI), .WO(WO), .WF(WF)) dut (
    .clk(clk), .reset(rst), .i_data(i_data), .i_valid(i_valid), .i_flow(i_flow),
    .i_eop(i_eop), .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid),
    .o_flow(o_flow), .o_eop(o_eop), .i_ready(rdy)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NI; i++) begin
      i_data[WO*i +: WO] = d[i];
      i_flow[WF*i +: WF] = f[i];
      i_valid[i] = v[i];
      i_eop[i] = e[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock: drive inputs, predict grant, then predict the registered output
  task automatic step(input bit r, input bit ready, input bit rnd);
    int gnt;
    bit ld, x;
    logic [NI-1:0] er;
    @(negedge clk);
    rst = r;
    rdy = ready;
    if (rnd)
      for (int i = 0; i < NI; i++)
        if (!(v[i] && !acc[i])) begin
          v[i] = $urandom_range(0, 3) != 0;
          d[i] = WO'($urandom);
          f[i] = WF'($urandom);
          e[i] = $urandom_range(0, 2) == 0;
        end
    #1;
    gnt = -1;
    if (m_lock) gnt = m_lk;
    else
      for (int k = 0; k < NI; k++)
        if (gnt < 0 && v[(m_ptr + k) % NI]) gnt = (m_ptr + k) % NI;
    ld = !m_valid || ready;
    er = (r || !ld || gnt < 0) ? '0 : NI'(1) << gnt;
    check("o_ready", 32'(o_ready), 32'(er));
    x = er != 0 && v[gnt];
    for (int i = 0; i < NI; i++) acc[i] = x && gnt == i;
    if (r) begin
      m_valid = 0; m_data = 0; m_flow = 0; m_eop = 0; m_ptr = 0; m_lock = 0; m_lk = 0;
    end else if (ld) begin
      m_valid = x;
      if (x) begin
        m_data = d[gnt];
        m_flow = f[gnt];
        m_eop = e[gnt];
`ifdef CT_MERGE_PKT_LOCK_EN
        m_lock = !e[gnt];
        if (!e[gnt]) m_lk = gnt;
        else m_ptr = (gnt + 1) % NI;
`else
        m_ptr = (gnt + 1) % NI;
`endif
      end
    end
    @(posedge clk);
    #1;
    check("o_valid", 32'(o_valid), 32'(m_valid));
    check("o_data", 32'(o_data), 32'(m_data));
    check("o_flow", 32'(o_flow), 32'(m_flow));
    check("o_eop", 32'(o_eop), 32'(m_eop));
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      v[i] = 1; e[i] = 1; d[i] = WO'(8'h10 * (i + 1)); f[i] = WF'(i); acc[i] = 0;
    end
    repeat (3) step(1, 1, 0);
    repeat (7) step(0, 1, 0);
    check("rr_last_src", 32'(o_data), 32'(8'h10));
    repeat (5) step(0, 0, 0);
    repeat (4) step(0, 1, 0);
    repeat (3000) step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ct_merge.md
# ct_merge

Multi-input merge node for the flow-tagged streaming fabric. It accepts beats carrying data, flow ID and end-of-packet from NI upstream sources and arbitrates between them round-robin. It emits a single registered stream that feeds a downstream ct_split or sink. Arbitration can be held for a whole packet so that beats from different sources never interleave.

## Interface
Parameters:
- NI, 2: number of inputs (≥1)
- WO, 8: data width per beat
- WF, 1: flow_id width

Ports:
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  synchronous, active-high
- i_data  input  NI*WO  input i data at [WO*i +: WO]
- i_valid  input  NI  per-input valid
- i_flow  input  NI*WF  input i flow_id at [WF*i +: WF]
- i_eop  input  NI  per-input end-of-packet marker
- o_ready  output  NI  per-input ready; at most one bit high
- o_data  output  WO  registered merged data
- o_valid  output  1  registered merged valid
- o_flow  output  WF  registered flow_id of o_data
- o_eop  output  1  registered end-of-packet
- i_ready  input  1  downstream ready

## Operation
- State: output register (o_data/o_flow/o_eop/o_valid), round-robin pointer ptr (width max(1,$clog2(NI))), lock flag, locked input index lk.
- load = !o_valid | i_ready; the output register accepts a new beat when load=1.
- Grant g, combinational:
  - If lock=1: g = lk.
  - Otherwise: g = first i with i_valid[i]=1, scanning ptr, ptr+1, … mod NI.
  - If no input is valid: no grant.
- o_ready[g] = load & !reset; all other o_ready bits are 0. o_ready is independent of i_valid[g]. A beat transfers on input g when i_valid[g] & o_ready[g].
- On transfer:
  - Output register loads i_data/i_flow/i_eop of g; o_valid <= 1.
  - If i_eop[g]=0: lock <= 1, lk <= g.
  - If i_eop[g]=1: lock <= 0, ptr <= (g+1) mod NI.
- If load=1 with no transfer: o_valid <= 0; data, flow and eop registers hold.
- If load=0: all registers hold.
- A single-beat packet (eop=1 on first beat) never sets lock.
- Locked state with i_valid[lk]=0 (bubble mid-packet): no other input is granted and o_valid drops after the held beat drains.
- NI=1: ptr is a constant 0; o_ready[0]=load.

## Timing
- Reset values: o_valid=0, o_data=0, o_flow=0, o_eop=0, ptr=0, lock=0, lk=0. o_ready=0 while reset is high.
- Latency: 1 cycle from input transfer to o_valid.
- Throughput: 1 beat/cycle sustained when i_ready=1.
- o_ready has a combinational path from i_ready; there is no skid buffer. Downstream must not make i_ready depend on o_valid through combinational logic that loops back.
- Simultaneous requests: lowest index at or after ptr wins. With ptr=0 and all valid, input 0 wins.
- Reset mid-packet: lock clears, any held output beat is discarded, and ptr returns to 0 on the next cycle.
- Upstream rules: an input must hold its beat stable while valid and not accepted. A downstream stall (i_ready=0 with o_valid=1) holds o_data/o_flow/o_eop stable.

## Configuration
- CT_MERGE_PKT_LOCK_EN defined: packet locking as described in Operation.
- Not defined:
  - lock/lk logic is removed and arbitration is per beat.
  - After every transfer, ptr <= (g+1) mod NI regardless of i_eop.
  - i_eop still passes through to o_eop unchanged.

## Test plan
- Reset behaviour: hold reset 3 cycles with all i_valid=1 → o_ready=0 and o_valid=0 throughout; the first grant after release goes to input 0.
- Round-robin fairness: NI=3, all inputs stream single-beat packets (eop=1), i_ready=1 → o_data source order 0,1,2,0,1,2; one beat per cycle, each 1 cycle after acceptance.
- Packet lock (macro on): input 1 sends a 4-beat packet (eop on beat 4) while input 0 is continuously valid → four consecutive beats come from input 1 before any beat from input 0.
- Per-beat interleave (macro off): same stimulus → output alternates inputs 1,0,1,0…
- Backpressure: i_ready=0 for 5 cycles with o_valid=1 → o_data, o_flow and o_eop stay constant and all o_ready=0. Release → the next beat appears 1 cycle later with no loss or duplication.
- Mid-packet reset and bubble:
  - Lock input 2 after its 2nd beat, assert reset 1 cycle → o_valid=0, and input 0 is granted first after release.
  - Separately, drop i_valid[lk] for 2 cycles while locked → no other input is granted.
